snow64_vector_alu_sequencer: RTL and testbench

- Element-serial sequencer upstream of the 64-bit integer ALU.
- Accepts one 256-bit vector operation: operands a/b, element size, ALU operation code and signedness.
- Feeds one element pair per cycle to the 64-bit ALU, after sign- or zero-extending each element to 64 bits.
- Truncates each ALU result back to the element size, packs the elements into a 256-bit result vector and holds it under a valid/ack handshake for register writeback.

---
 rtl/snow64_vector_alu_sequencer_if.sv | 34 +++
 rtl/snow64_vector_alu_sequencer.sv | 124 ++++++++++++
 tb/tb_snow64_vector_alu_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/snow64_vector_alu_sequencer_if.sv
// Bus bundle between the vector sequencer, its requester, the 64-bit ALU and the writeback consumer.
interface snow64_vector_alu_sequencer_if #(
    parameter int unsigned WIDTH__VECTOR = 256,
    parameter int unsigned WIDTH__ALU    = 64,
    parameter int unsigned WIDTH__OPER   = 4
);
    logic                     in_start;
    logic                     out_ready;
    logic [WIDTH__VECTOR-1:0] in_a;
    logic [WIDTH__VECTOR-1:0] in_b;
    logic [1:0]               in_size;
    logic [WIDTH__OPER-1:0]   in_oper;
    logic                     in_unsgn_or_sgn;
    logic [WIDTH__ALU-1:0]    out_alu_a;
    logic [WIDTH__ALU-1:0]    out_alu_b;
    logic [WIDTH__OPER-1:0]   out_alu_oper;
    logic                     out_alu_unsgn_or_sgn;
    logic [WIDTH__ALU-1:0]    in_alu_result;
    logic                     out_valid;
    logic                     in_ack;
    logic [WIDTH__VECTOR-1:0] out_result;

    modport slave (
        input  in_start, in_a, in_b, in_size, in_oper, in_unsgn_or_sgn, in_alu_result, in_ack,
        output out_ready, out_alu_a, out_alu_b, out_alu_oper, out_alu_unsgn_or_sgn, out_valid,
               out_result
    );

    modport master (
        output in_start, in_a, in_b, in_size, in_oper, in_unsgn_or_sgn, in_alu_result, in_ack,
        input  out_ready, out_alu_a, out_alu_b, out_alu_oper, out_alu_unsgn_or_sgn, out_valid,
               out_result
    );
endinterface

// File: rtl/snow64_vector_alu_sequencer.sv
// Element-serial sequencer: walks a 256-bit vector op through a 64-bit ALU one element per cycle
// and packs the truncated results into a vector held under a valid/ack handshake.
module snow64_vector_alu_sequencer #(
    parameter int unsigned WIDTH__VECTOR = 256,
    parameter int unsigned WIDTH__ALU    = 64,
    parameter int unsigned WIDTH__OPER   = 4
) (
    input logic                          clk,
    input logic                          rst,
    snow64_vector_alu_sequencer_if.slave bus_io
);
    localparam int unsigned NMax = WIDTH__VECTOR / 8;
    localparam int unsigned IdxW = $clog2(NMax);
    localparam int unsigned ShW  = $clog2(WIDTH__VECTOR);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                   state_q;
    logic [IdxW-1:0]          idx_q;
    logic [WIDTH__VECTOR-1:0] a_q, b_q, result_q;
    logic [1:0]               size_q;
    logic [WIDTH__OPER-1:0]   oper_q;
    logic                     sgn_q;
    logic                     ready_q, valid_q;

    logic [ShW-1:0]           shamt;
    logic [IdxW-1:0]          last_idx;
    logic [WIDTH__ALU-1:0]    raw_a, raw_b, alu_a, alu_b;
    logic [WIDTH__VECTOR-1:0] lane_mask, lane_data, result_d;

    // Keep the low element of raw and fill the rest with zero or the element's sign bit.
    function automatic logic [WIDTH__ALU-1:0] extend(input logic [WIDTH__ALU-1:0] raw,
                                                     input logic [1:0] size, input logic sgn);
        logic fill;
        case (size)
            2'd0: begin
                fill = sgn & raw[7];
                return {{(WIDTH__ALU-8){fill}}, raw[7:0]};
            end
            2'd1: begin
                fill = sgn & raw[15];
                return {{(WIDTH__ALU-16){fill}}, raw[15:0]};
            end
            2'd2: begin
                fill = sgn & raw[31];
                return {{(WIDTH__ALU-32){fill}}, raw[31:0]};
            end
            default: return raw;
        endcase
    endfunction

    always_comb begin
        shamt     = ShW'(idx_q) << ({1'b0, size_q} + 3'd3);
        last_idx  = IdxW'((NMax >> size_q) - 1);
        raw_a     = WIDTH__ALU'(a_q >> shamt);
        raw_b     = WIDTH__ALU'(b_q >> shamt);
        alu_a     = '0;
        alu_b     = '0;
        if (state_q == StRun) begin
            alu_a = extend(raw_a, size_q, sgn_q);
            alu_b = extend(raw_b, size_q, sgn_q);
        end
        lane_mask = WIDTH__VECTOR'(extend({WIDTH__ALU{1'b1}}, size_q, 1'b0)) << shamt;
        lane_data = WIDTH__VECTOR'(extend(bus_io.in_alu_result, size_q, 1'b0)) << shamt;
        result_d  = (result_q & ~lane_mask) | lane_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            size_q   <= '0;
            oper_q   <= '0;
            sgn_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus_io.in_start) begin
                        a_q      <= bus_io.in_a;
                        b_q      <= bus_io.in_b;
                        size_q   <= bus_io.in_size;
                        oper_q   <= bus_io.in_oper;
                        sgn_q    <= bus_io.in_unsgn_or_sgn;
                        result_q <= '0;
                        idx_q    <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    result_q <= result_d;
                    if (idx_q == last_idx) begin
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus_io.in_ack) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.out_ready            = ready_q;
    assign bus_io.out_valid            = valid_q;
    assign bus_io.out_result           = result_q;
    assign bus_io.out_alu_a            = alu_a;
    assign bus_io.out_alu_b            = alu_b;
    assign bus_io.out_alu_oper         = oper_q;
    assign bus_io.out_alu_unsgn_or_sgn = sgn_q;
endmodule

// File: tb/tb_snow64_vector_alu_sequencer.sv
// Scoreboard bench: a behavioural 64-bit ALU closes the loop; the driver queues hand-computed
// result vectors and a monitor compares them when out_valid rises.
module tb_snow64_vector_alu_sequencer;
    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpSlt = 4'd2;
    localparam logic [3:0] OpSra = 4'd3;

    typedef struct {
        logic [255:0] res;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   accepts = 0;
    logic count_en = 1'b0;
    exp_t sb[$];

    snow64_vector_alu_sequencer_if #(
        .WIDTH__VECTOR(256), .WIDTH__ALU(64), .WIDTH__OPER(4)
    ) bus ();

    snow64_vector_alu_sequencer #(
        .WIDTH__VECTOR(256), .WIDTH__ALU(64), .WIDTH__OPER(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (count_en && bus.in_start && bus.out_ready) accepts <= accepts + 1;
    end

    function automatic logic [63:0] alu(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] op, input logic s);
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpSlt:   return s ? {63'b0, $signed(a) < $signed(b)} : {63'b0, a < b};
            OpSra:   return s ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
            default: return a ^ b;
        endcase
    endfunction

    always_comb bus.in_alu_result = alu(bus.out_alu_a, bus.out_alu_b, bus.out_alu_oper,
                                        bus.out_alu_unsgn_or_sgn);

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: pops one expectation on each rising edge of out_valid.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 256'd1, 256'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.out_result, e.res);
                    if (e.lat >= 0) check("latency", 256'(cyc - accept_cyc), 256'(e.lat));
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [1:0] size,
                          input logic [3:0] oper, input logic sgn, input logic [255:0] exp_res,
                          input logic [63:0] exp_alu_a, input logic [63:0] exp_alu_b,
                          input int hold);
        exp_t e;
        int   n;
        e.res = exp_res;
        e.lat = 32 >> size;
        sb.push_back(e);
        @(negedge clk);
        check("ready_before_start", 256'(bus.out_ready), 256'd1);
        bus.in_a            = a;
        bus.in_b            = b;
        bus.in_size         = size;
        bus.in_oper         = oper;
        bus.in_unsgn_or_sgn = sgn;
        bus.in_start        = 1'b1;
        @(negedge clk);
        accept_cyc   = cyc;
        bus.in_start = 1'b0;
        check("alu_a_elem0", 256'(bus.out_alu_a), 256'(exp_alu_a));
        check("alu_b_elem0", 256'(bus.out_alu_b), 256'(exp_alu_b));
        check("alu_oper", 256'(bus.out_alu_oper), 256'(oper));
        bus.in_a    = ~a;
        bus.in_b    = ~b;
        bus.in_size = ~size;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) check("valid_timeout", 256'd0, 256'd1);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 256'(bus.out_valid), 256'd1);
            check("hold_result", bus.out_result, exp_res);
            check("done_alu_a_zero", 256'(bus.out_alu_a), 256'd0);
            bus.in_start = (i == 1);
            @(negedge clk);
            bus.in_start = 1'b0;
            check("ready_low_in_done", 256'(bus.out_ready), 256'd0);
        end
        bus.in_ack = 1'b1;
        @(negedge clk);
        bus.in_ack = 1'b0;
        check("valid_cleared_by_ack", 256'(bus.out_valid), 256'd0);
        check("ready_after_ack", 256'(bus.out_ready), 256'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_start        = 1'b0;
        bus.in_a            = '0;
        bus.in_b            = '0;
        bus.in_size         = '0;
        bus.in_oper         = '0;
        bus.in_unsgn_or_sgn = 1'b0;
        bus.in_ack          = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 256'(bus.out_ready), 256'd1);
        check("rst_valid", 256'(bus.out_valid), 256'd0);
        check("rst_result", bus.out_result, 256'd0);
        check("rst_alu_a", 256'(bus.out_alu_a), 256'd0);
        rst = 1'b0;

        // 8-bit add, each byte wraps to zero
        run_op({32{8'hFF}}, {32{8'h01}}, 2'd0, OpAdd, 1'b1, 256'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op({32{8'hFF}}, {32{8'h01}}, 2'd0, OpAdd, 1'b0, 256'd0, 64'hFF, 64'd1, 0);
        // 16-bit set-less-than
        run_op({16{16'hFFFF}}, {16{16'h0001}}, 2'd1, OpSlt, 1'b1, {16{16'h0001}},
               64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op({16{16'hFFFF}}, {16{16'h0001}}, 2'd1, OpSlt, 1'b0, 256'd0, 64'hFFFF, 64'd1, 0);
        // 32-bit arithmetic shift right by 4
        run_op({8{32'h8000_0000}}, {8{32'd4}}, 2'd2, OpSra, 1'b1, {8{32'hF800_0000}},
               64'hFFFF_FFFF_8000_0000, 64'd4, 0);
        run_op({8{32'h8000_0000}}, {8{32'd4}}, 2'd2, OpSra, 1'b0, {8{32'h0800_0000}},
               64'h8000_0000, 64'd4, 0);
        // 64-bit sub with 5 cycles of backpressure and a start pulse during DONE
        run_op({64'd13, 64'd12, 64'd11, 64'd10}, {4{64'd3}}, 2'd3, OpSub, 1'b1,
               {64'd10, 64'd9, 64'd8, 64'd7}, 64'd10, 64'd3, 5);

        // Reset in the fifth cycle of an 8-bit op
        @(negedge clk);
        bus.in_a            = {32{8'h5A}};
        bus.in_b            = {32{8'h11}};
        bus.in_size         = 2'd0;
        bus.in_oper         = OpAdd;
        bus.in_unsgn_or_sgn = 1'b1;
        bus.in_start        = 1'b1;
        @(negedge clk);
        bus.in_start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_ready_low", 256'(bus.out_ready), 256'd0);
        rst = 1'b1;
        #1;
        check("midrst_ready", 256'(bus.out_ready), 256'd1);
        check("midrst_valid", 256'(bus.out_valid), 256'd0);
        check("midrst_result", bus.out_result, 256'd0);
        check("midrst_alu_a", 256'(bus.out_alu_a), 256'd0);
        check("midrst_alu_b", 256'(bus.out_alu_b), 256'd0);
        check("midrst_oper", 256'(bus.out_alu_oper), 256'd0);
        check("midrst_sgn", 256'(bus.out_alu_unsgn_or_sgn), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op({64'd400, 64'd300, 64'd200, 64'd100}, {64'd4, 64'd3, 64'd2, 64'd1}, 2'd3, OpSub,
               1'b0, {64'd396, 64'd297, 64'd198, 64'd99}, 64'd100, 64'd1, 0);

        // Start and ack held high: two full ops in 12 cycles, one accept per IDLE visit
        begin
            exp_t e;
            int   ready_hi;
            e.res = {64'd10, 64'd9, 64'd8, 64'd7};
            e.lat = -1;
            sb.push_back(e);
            sb.push_back(e);
            @(negedge clk);
            bus.in_a            = {64'd13, 64'd12, 64'd11, 64'd10};
            bus.in_b            = {4{64'd3}};
            bus.in_size         = 2'd3;
            bus.in_oper         = OpSub;
            bus.in_unsgn_or_sgn = 1'b1;
            bus.in_start        = 1'b1;
            bus.in_ack          = 1'b1;
            count_en            = 1'b1;
            ready_hi            = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus.out_ready) ready_hi++;
            end
            count_en     = 1'b0;
            bus.in_start = 1'b0;
            bus.in_ack   = 1'b0;
            check("held_start_accepts", 256'(accepts), 256'd2);
            check("held_start_ready_cycles", 256'(ready_hi), 256'd2);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 256'(sb.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
